// File: rtl/rms_gamma_scale.sv
`default_nettype none
// ============================================================================
// Module   : rms_gamma_scale
// Brief    : Per-channel bf16 gamma scaling of the rmsnorm output stream,
//            3-stage pipeline, 1 element/cycle, per-vector last flag.
// Revision : 1.0 - initial release
// ============================================================================
module rms_gamma_scale #(
    parameter int DIM    = 768,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_tvalid,
    input  logic [31:0]       a_tdata,
    input  logic              g_wr_en,
    input  logic [ADDR_W-1:0] g_wr_addr,
    input  logic [15:0]       g_wr_data,
    output logic              result_tvalid,
    output logic [31:0]       result_tdata,
    output logic              result_tlast
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DIM - 1);

    localparam logic [1:0] CLS_NUM  = 2'd0;
    localparam logic [1:0] CLS_NAN  = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_ZERO = 2'd3;

    localparam logic [15:0] QNAN = 16'h7FC0;

    logic unused_lo;
    assign unused_lo = ^a_tdata[15:0];

    // Gamma storage is deliberately outside the reset domain.
    logic [15:0] gamma_q [DIM];

    always_ff @(posedge clk) begin
        if (g_wr_en && (g_wr_addr <= LAST_IDX)) begin
            gamma_q[g_wr_addr] <= g_wr_data;
        end
    end

    logic [ADDR_W-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (a_tvalid) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    // ---------------- Stage 1: capture operands ----------------
    logic        s1_valid_q, s1_last_q;
    logic [15:0] s1_a_q, s1_g_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_a_q     <= '0;
            s1_g_q     <= '0;
        end else begin
            idx_q      <= idx_d;
            s1_valid_q <= a_tvalid;
            s1_last_q  <= a_tvalid && (idx_q == LAST_IDX);
            if (a_tvalid) begin
                s1_a_q <= a_tdata[31:16];
                s1_g_q <= gamma_q[idx_q];
            end
        end
    end

    // ---------------- Stage 2: classify, exponent sum, mantissa product ----
    logic [7:0]        w_ea, w_eb;
    logic [6:0]        w_fa, w_fb;
    logic              w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    logic [1:0]        w_cls;
    logic signed [9:0] w_exp_sum;
    logic [15:0]       w_prod;

    assign w_ea     = s1_a_q[14:7];
    assign w_eb     = s1_g_q[14:7];
    assign w_fa     = s1_a_q[6:0];
    assign w_fb     = s1_g_q[6:0];
    assign w_nan_a  = (w_ea == 8'hFF) && (w_fa != 7'd0);
    assign w_nan_b  = (w_eb == 8'hFF) && (w_fb != 7'd0);
    assign w_inf_a  = (w_ea == 8'hFF) && (w_fa == 7'd0);
    assign w_inf_b  = (w_eb == 8'hFF) && (w_fb == 7'd0);
    assign w_zero_a = (w_ea == 8'h00);
    assign w_zero_b = (w_eb == 8'h00);

    always_comb begin
        w_cls = CLS_NUM;
        if (w_nan_a || w_nan_b) begin
            w_cls = CLS_NAN;
        end else if ((w_inf_a && w_zero_b) || (w_inf_b && w_zero_a)) begin
            w_cls = CLS_NAN;
        end else if (w_inf_a || w_inf_b) begin
            w_cls = CLS_INF;
        end else if (w_zero_a || w_zero_b) begin
            w_cls = CLS_ZERO;
        end
    end

    assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;
    assign w_prod    = 16'({1'b1, w_fa}) * 16'({1'b1, w_fb});

    logic              s2_valid_q, s2_last_q, s2_sign_q;
    logic [1:0]        s2_cls_q;
    logic signed [9:0] s2_exp_q;
    logic [15:0]       s2_prod_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_cls_q   <= CLS_NUM;
            s2_exp_q   <= '0;
            s2_prod_q  <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            if (s1_valid_q) begin
                s2_sign_q <= s1_a_q[15] ^ s1_g_q[15];
                s2_cls_q  <= w_cls;
                s2_exp_q  <= w_exp_sum;
                s2_prod_q <= w_prod;
            end
        end
    end

    // ---------------- Stage 3: normalize, round (RNE), pack -----------------
    logic signed [9:0] w_norm_exp, w_fin_exp;
    logic [6:0]        w_frac;
    logic              w_guard, w_sticky, w_round_up;
    logic [8:0]        w_mant_rnd;
    logic [15:0]       w_res;

    always_comb begin
        if (s2_prod_q[15]) begin
            w_frac   = s2_prod_q[14:8];
            w_guard  = s2_prod_q[7];
            w_sticky = |s2_prod_q[6:0];
        end else begin
            w_frac   = s2_prod_q[13:7];
            w_guard  = s2_prod_q[6];
            w_sticky = |s2_prod_q[5:0];
        end
    end

    assign w_norm_exp = s2_exp_q + $signed({9'd0, s2_prod_q[15]});
    assign w_round_up = w_guard && (w_sticky || w_frac[0]);
    assign w_mant_rnd = {1'b0, 1'b1, w_frac} + {8'd0, w_round_up};
    assign w_fin_exp  = w_norm_exp + $signed({9'd0, w_mant_rnd[8]});

    always_comb begin
        w_res = {s2_sign_q, 15'd0};
        case (s2_cls_q)
            CLS_NAN:  w_res = QNAN;
            CLS_INF:  w_res = {s2_sign_q, 8'hFF, 7'd0};
            CLS_ZERO: w_res = {s2_sign_q, 15'd0};
            default: begin
                if (w_fin_exp >= 10'sd255) begin
                    w_res = {s2_sign_q, 8'hFF, 7'd0};
                end else if (w_fin_exp <= 10'sd0) begin
                    w_res = {s2_sign_q, 15'd0};
                end else begin
                    w_res = {s2_sign_q, w_fin_exp[7:0], w_mant_rnd[6:0]};
                end
            end
        endcase
    end

    logic        out_valid_q, out_last_q;
    logic [31:0] out_data_q, out_data_d;

    assign out_data_d = s2_valid_q ? {w_res, 16'h0000} : out_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= s2_valid_q;
            out_last_q  <= s2_valid_q && s2_last_q;
            out_data_q  <= out_data_d;
        end
    end

    assign result_tvalid = out_valid_q;
    assign result_tlast  = out_last_q;
    assign result_tdata  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_rms_gamma_scale.sv
`default_nettype none
// ============================================================================
// Module   : tb_rms_gamma_scale
// Brief    : Randomized scoreboard bench for rms_gamma_scale with an
//            arithmetic bf16 reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rms_gamma_scale;

    localparam int DIM    = 768;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              a_tvalid = 1'b0;
    logic [31:0]       a_tdata = '0;
    logic              g_wr_en = 1'b0;
    logic [ADDR_W-1:0] g_wr_addr = '0;
    logic [15:0]       g_wr_data = '0;
    logic              result_tvalid;
    logic [31:0]       result_tdata;
    logic              result_tlast;

    rms_gamma_scale #(.DIM(DIM), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .a_tvalid      (a_tvalid),
        .a_tdata       (a_tdata),
        .g_wr_en       (g_wr_en),
        .g_wr_addr     (g_wr_addr),
        .g_wr_data     (g_wr_data),
        .result_tvalid (result_tvalid),
        .result_tdata  (result_tdata),
        .result_tlast  (result_tlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] gm [DIM];
    int          m_idx       = 0;
    int          cyc         = 0;
    int          n_checks    = 0;
    int          n_err       = 0;
    int          n_out       = 0;
    int          n_last_obs  = 0;
    int          n_exp_total = 0;
    int          n_last_exp  = 0;
    logic        mon_en      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Exact significand product, then a generic round-to-nearest-even to 8 significant bits.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, fa, fb, p, k, e, sh, q, rem, half;
        logic s;
        logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        ea = int'(a[14:7]); eb = int'(b[14:7]);
        fa = int'(a[6:0]);  fb = int'(b[6:0]);
        s  = a[15] ^ b[15];
        nan_a  = (ea == 255) && (fa != 0);
        nan_b  = (eb == 255) && (fb != 0);
        inf_a  = (ea == 255) && (fa == 0);
        inf_b  = (eb == 255) && (fb == 0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        if (nan_a || nan_b) return 16'h7FC0;
        if ((inf_a && zero_b) || (inf_b && zero_a)) return 16'h7FC0;
        if (inf_a || inf_b) return {s, 8'hFF, 7'd0};
        if (zero_a || zero_b) return {s, 15'd0};
        p = (128 + fa) * (128 + fb);
        k = 20;
        while (((p >> k) & 1) == 0) k--;
        e    = ea + eb - 127 - 14 + k;
        sh   = k - 7;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 1 << (sh - 1);
        if ((rem > half) || ((rem == half) && ((q & 1) == 1))) q++;
        if (q == 256) begin
            q = 128;
            e++;
        end
        if (e >= 255) return {s, 8'hFF, 7'd0};
        if (e <= 0) return {s, 15'd0};
        return {s, 8'(e), 7'(q - 128)};
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic we,
                         input logic [ADDR_W-1:0] wa, input logic [15:0] wd,
                         input logic ovr, input logic [15:0] ovr_val);
        exp_t e;
        @(negedge clk);
        a_tvalid  = v;
        a_tdata   = a;
        g_wr_en   = we;
        g_wr_addr = wa;
        g_wr_data = wd;
        if (v) begin
            e.data = ovr ? ovr_val : ref_mul(a[31:16], gm[m_idx]);
            e.last = (m_idx == DIM - 1);
            e.cyc  = cyc + 3;
            exp_q.push_back(e);
            n_exp_total++;
            if (e.last) n_last_exp++;
            m_idx = (m_idx == DIM - 1) ? 0 : m_idx + 1;
        end
        if (we && (int'(wa) < DIM)) gm[wa] = wd;
    endtask

    task automatic idle();
        drive(1'b0, $urandom, 1'b0, '0, '0, 1'b0, '0);
    endtask

    function automatic logic [31:0] rand_normal();
        logic [31:0] r;
        r = $urandom;
        r[30:23] = 8'($urandom_range(1, 254));
        return r;
    endfunction

    // Write gamma at the current element index, then send one element the next cycle.
    task automatic pair(input logic [15:0] a, input logic [15:0] g, input logic [15:0] expv);
        drive(1'b0, '0, 1'b1, ADDR_W'(m_idx), g, 1'b0, '0);
        drive(1'b1, {a, 16'($urandom)}, 1'b0, '0, '0, 1'b1, expv);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < 20)) begin
            idle();
            n++;
        end
        idle();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            while ((exp_q.size() != 0) && (exp_q[0].cyc < cyc)) begin
                chk("missing_out", 32'(exp_q[0].cyc), 32'(cyc));
                void'(exp_q.pop_front());
            end
            if (result_tvalid) begin
                exp_t e;
                n_out++;
                if (result_tlast) n_last_obs++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {31'd0, result_tvalid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", 32'(cyc), 32'(e.cyc));
                    chk("data", result_tdata, {e.data, 16'h0000});
                    chk("last", {31'd0, result_tlast}, {31'd0, e.last});
                end
            end else begin
                chk("idle_last", {31'd0, result_tlast}, 32'd0);
            end
        end
    end

    initial begin
        int out0, last0;
        foreach (gm[i]) gm[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, result_tvalid}, 32'd0);
        chk("rst_data", result_tdata, 32'd0);
        chk("rst_last", {31'd0, result_tlast}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Identity gamma: outputs must reproduce inputs
        for (int i = 0; i < DIM; i++) drive(1'b0, '0, 1'b1, ADDR_W'(i), 16'h3F80, 1'b0, '0);
        for (int i = 0; i < DIM; i++) begin
            logic [31:0] r;
            r = rand_normal();
            drive(1'b1, r, 1'b0, '0, '0, 1'b1, r[31:16]);
        end
        drain();

        // Directed arithmetic cases
        pair(16'h3FC0, 16'h4000, 16'h4040);
        pair(16'h4040, 16'h3F00, 16'h3FC0);
        pair(16'hBFC0, 16'h4000, 16'hC040);
        pair(16'h3F81, 16'h3F81, 16'h3F82);
        pair(16'h7F00, 16'h4000, 16'h7F80);
        pair(16'h0080, 16'h0080, 16'h0000);
        pair(16'h0001, 16'hBF80, 16'h8000);
        pair(16'h7FC0, 16'h3F80, 16'h7FC0);
        pair(16'h7F80, 16'h0000, 16'h7FC0);
        pair(16'hFF80, 16'h4000, 16'hFF80);
        // Same-cycle write and read of one index must use the old value (1.0)
        drive(1'b0, '0, 1'b1, ADDR_W'(m_idx), 16'h3F80, 1'b0, '0);
        drive(1'b1, 32'h3FC0_1234, 1'b1, ADDR_W'(m_idx), 16'h4000, 1'b1, 16'h3FC0);
        drain();

        // Random gamma, including writes to out-of-range addresses
        for (int i = 0; i < DIM; i++) drive(1'b0, '0, 1'b1, ADDR_W'(i), 16'($urandom), 1'b0, '0);
        drive(1'b0, '0, 1'b1, ADDR_W'(DIM), 16'hFFFF, 1'b0, '0);
        drive(1'b0, '0, 1'b1, ADDR_W'(1023), 16'hFFFF, 1'b0, '0);

        // Full-length stream with random gaps and occasional gamma updates
        out0  = n_out;
        last0 = n_last_obs;
        for (int i = 0; i < 64 * DIM; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                drive(1'b0, $urandom, ($urandom_range(0, 63) == 0),
                      ADDR_W'($urandom_range(0, 1023)), 16'($urandom), 1'b0, '0);
            end
            drive(1'b1, $urandom, 1'b0, '0, '0, 1'b0, '0);
        end
        drain();
        chk("stream_outputs", 32'(n_out - out0), 32'(64 * DIM));
        chk("stream_lasts", 32'(n_last_obs - last0), 32'd64);

        // Reset mid-stream: in-flight elements vanish, index restarts
        for (int i = 0; i < 100; i++) drive(1'b1, rand_normal(), 1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        rst_n    = 1'b0;
        a_tvalid = 1'b0;
        foreach (exp_q[i]) begin
            n_exp_total--;
            if (exp_q[i].last) n_last_exp--;
        end
        exp_q.delete();
        m_idx = 0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_valid", {31'd0, result_tvalid}, 32'd0);
            chk("midrst_data", result_tdata, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < DIM + 40; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            drive(1'b1, rand_normal(), 1'b0, '0, '0, 1'b0, '0);
        end
        drain();

        chk("total_outputs", 32'(n_out), 32'(n_exp_total));
        chk("total_lasts", 32'(n_last_obs), 32'(n_last_exp));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
